// File: rtl/ul_drp_arb_pkg.sv
// ----------------------------------------------------------------------------
// ul_drp_arb_pkg
// Shared definitions for the DRP command-stream arbiter:
//   - arb_state_e      : sequencer FSM encoding (IDLE, ISSUE, WAIT, RESP)
//   - GP_PORT_DRP_*    : bridge command word field positions, mirrored from the
//                        register-map header
//   - idx_w()          : width of a requester index (at least one bit)
// ----------------------------------------------------------------------------
package ul_drp_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  // Bridge command word layout.
  localparam int GP_PORT_DRP_DATA_LSB = 0;   // [15:0]  DRP write data
  localparam int GP_PORT_DRP_DATA_W   = 16;
  localparam int GP_PORT_DRP_ADDR_LSB = 16;  // [25:16] DRP address
  localparam int GP_PORT_DRP_ADDR_W   = 10;
  localparam int GP_PORT_DRP_SEL_LSB  = 26;  // [27:26] DRP port select
  localparam int GP_PORT_DRP_SEL_W    = 2;
  localparam int GP_PORT_DRP_WEN      = 28;  // 1 = DRP write, 0 = DRP read
  localparam int GP_PORT_DRP_REGEN    = 31;  // 1 = DRP register access, 0 = GPIO/select only

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ul_rr_pick.sv
// ----------------------------------------------------------------------------
// ul_rr_pick
// Combinational round-robin winner selection. Searches upward from last+1,
// wrapping modulo REQS, and returns the first requester with valid set.
// Ports:
//   valid [REQS-1:0] : request vector
//   last  [IW-1:0]   : index of the previous winner
//   any              : at least one request present
//   grant [REQS-1:0] : one-hot winner (all zero when any = 0)
//   idx   [IW-1:0]   : winner index (0 when any = 0)
// ----------------------------------------------------------------------------
module ul_rr_pick
  import ul_drp_arb_pkg::*;
#(
  parameter  int REQS = 2,
  localparam int IW   = idx_w(REQS)
) (
  input  logic [REQS-1:0] valid,
  input  logic [IW-1:0]   last,
  output logic            any,
  output logic [REQS-1:0] grant,
  output logic [IW-1:0]   idx
);

  int cand;

  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    any   = 1'b0;
    grant = '0;
    idx   = '0;
    cand  = 0;
    for (int off = 1; off <= REQS; off++) begin
      cand = (int'(last) + off) % REQS;
      for (int i = 0; i < REQS; i++) begin
        if (!any && (cand == i) && valid[i]) begin
          any      = 1'b1;
          grant[i] = 1'b1;
          idx      = IW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/ul_drp_arb.sv
// ----------------------------------------------------------------------------
// ul_drp_arb
// Round-robin arbiter and transaction sequencer that shares the DRP bridge's
// 32-bit command stream among REQS requesters. One transaction in flight; the
// grant is held until the bridge completes, then the captured status word is
// returned to the owning requester only.
//
// Optional feature: define UL_DRP_ARB_TIMEOUT_EN to bound WAIT to TO_CYCLES
// cycles; a timed-out access responds with resp_err = 1 and resp_data = 0.
// Without it WAIT is unbounded and resp_err is tied to 0.
//
// Ports:
//   axis_clk, reset_n      : clock, asynchronous active-low reset
//   req_data  [32*REQS-1:0]: command word per requester (slice i = [32i+31:32i])
//   req_valid [REQS-1:0]   : command present
//   req_ready [REQS-1:0]   : one-cycle accept pulse to the granted requester
//   resp_data [31:0]       : status word of the last completed transaction
//   resp_valid[REQS-1:0]   : one-cycle completion pulse to the owner
//   resp_err               : qualifies resp_valid, 1 = timeout
//   m_cmd_data/m_cmd_valid/m_cmd_ready : command stream to the bridge
//   m_stat_data            : bridge status word
//   m_drdy                 : DRP ready of the selected port
// ----------------------------------------------------------------------------
module ul_drp_arb
  import ul_drp_arb_pkg::*;
#(
  parameter int REQS      = 2,
  parameter int TO_CYCLES = 1023
) (
  input  logic              axis_clk,
  input  logic              reset_n,
  input  logic [32*REQS-1:0] req_data,
  input  logic [REQS-1:0]   req_valid,
  output logic [REQS-1:0]   req_ready,
  output logic [31:0]       resp_data,
  output logic [REQS-1:0]   resp_valid,
  output logic              resp_err,
  output logic [31:0]       m_cmd_data,
  output logic              m_cmd_valid,
  input  logic              m_cmd_ready,
  input  logic [31:0]       m_stat_data,
  input  logic              m_drdy
);

  localparam int IW = idx_w(REQS);

  arb_state_e      state_q, state_d;
  logic [IW-1:0]   last_q;
  logic [31:0]     cmd_q;
  logic [31:0]     stat_q;
  logic            got_q;
  logic            armed_q;
  logic [REQS-1:0] resp_valid_q;

  logic            win_any;
  logic [REQS-1:0] win_grant;
  logic [IW-1:0]   win_idx;
  logic [31:0]     win_word;
  logic [REQS-1:0] last_onehot;
  logic            accept;
  logic            wait_done;
  logic            wait_to;
  logic            timeout_hit;

  ul_rr_pick #(.REQS(REQS)) u_pick (
    .valid (req_valid),
    .last  (last_q),
    .any   (win_any),
    .grant (win_grant),
    .idx   (win_idx)
  );

  always_comb begin
    win_word    = '0;
    last_onehot = '0;
    for (int i = 0; i < REQS; i++) begin
      if (win_grant[i]) win_word = req_data[32*i +: 32];
      last_onehot[i] = (int'(last_q) == i);
    end
  end

`ifdef UL_DRP_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic          to_q;
  logic          resp_err_q;

  assign timeout_hit = (state_q == ST_WAIT) && (cnt_q == CW'(TO_CYCLES));

  // Counter is held at zero through ISSUE, so it starts from 0 on the first
  // WAIT cycle and saturates at TO_CYCLES.
  always_ff @(posedge axis_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      to_q       <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      if (state_q == ST_ISSUE) begin
        cnt_q <= '0;
        to_q  <= 1'b0;
      end else if (state_q == ST_WAIT) begin
        if (!timeout_hit) cnt_q <= cnt_q + 1'b1;
        if (wait_to)      to_q  <= 1'b1;
      end
      resp_err_q <= (state_q == ST_RESP) && to_q;
    end
  end

  assign resp_err = resp_err_q;
`else
  assign timeout_hit = 1'b0;
  assign resp_err    = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    accept    = 1'b0;
    wait_done = 1'b0;
    wait_to   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // armed_q keeps req_ready low while reset is asserted and on the
        // reset-release edge, so every output is 0 during reset.
        if (armed_q && win_any) begin
          accept    = 1'b1;
          req_ready = win_grant;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (m_cmd_ready) state_d = cmd_q[GP_PORT_DRP_REGEN] ? ST_WAIT : ST_RESP;
      end
      ST_WAIT: begin
        // A drdy in the same cycle as ready counts as the capture.
        wait_done = m_cmd_ready && (got_q || m_drdy);
        wait_to   = !wait_done && timeout_hit;
        if (wait_done || wait_to) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge axis_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      last_q       <= IW'(REQS - 1);
      cmd_q        <= '0;
      stat_q       <= '0;
      got_q        <= 1'b0;
      armed_q      <= 1'b0;
      resp_valid_q <= '0;
    end else begin
      state_q      <= state_d;
      armed_q      <= 1'b1;
      resp_valid_q <= (state_q == ST_RESP) ? last_onehot : '0;
      if (accept) begin
        cmd_q  <= win_word;
        last_q <= win_idx;
      end
      if (state_q == ST_ISSUE && m_cmd_ready) begin
        got_q <= 1'b0;
        if (!cmd_q[GP_PORT_DRP_REGEN]) stat_q <= m_stat_data;
      end
      if (state_q == ST_WAIT && m_drdy && !got_q) begin
        stat_q <= m_stat_data;
        got_q  <= 1'b1;
      end
      if (wait_to) stat_q <= '0;
    end
  end

  assign m_cmd_valid = (state_q == ST_ISSUE);
  assign m_cmd_data  = cmd_q;
  assign resp_data   = stat_q;
  assign resp_valid  = resp_valid_q;

endmodule

// File: tb/tb_ul_drp_arb.sv
// ----------------------------------------------------------------------------
// tb_ul_drp_arb
// Directed sequence with randomized command/status words and DRP latencies.
// Expected grants come from a round-robin rule on the request mask; expected
// response timing comes from the transaction rules (one ISSUE cycle, WAIT
// until ready with data captured, one RESP cycle, then the pulse).
// Timeout scenario runs when UL_DRP_ARB_TIMEOUT_EN is defined.
// ----------------------------------------------------------------------------
module tb_ul_drp_arb;
  import ul_drp_arb_pkg::*;

  localparam int REQS      = 2;
  localparam int TO_CYCLES = 16;

  logic              axis_clk = 1'b0;
  logic              reset_n  = 1'b0;
  logic [32*REQS-1:0] req_data;
  logic [REQS-1:0]   req_valid;
  logic [REQS-1:0]   req_ready;
  logic [31:0]       resp_data;
  logic [REQS-1:0]   resp_valid;
  logic              resp_err;
  logic [31:0]       m_cmd_data;
  logic              m_cmd_valid;
  logic              m_cmd_ready;
  logic [31:0]       m_stat_data;
  logic              m_drdy;

  always #5 axis_clk = ~axis_clk;

  ul_drp_arb #(.REQS(REQS), .TO_CYCLES(TO_CYCLES)) dut (
    .axis_clk    (axis_clk),
    .reset_n     (reset_n),
    .req_data    (req_data),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .resp_data   (resp_data),
    .resp_valid  (resp_valid),
    .resp_err    (resp_err),
    .m_cmd_data  (m_cmd_data),
    .m_cmd_valid (m_cmd_valid),
    .m_cmd_ready (m_cmd_ready),
    .m_stat_data (m_stat_data),
    .m_drdy      (m_drdy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int hs_n  = 0;
  int resp_n = 0;
  int last_cyc;
  logic [1:0]  last_v;
  logic [31:0] last_d;
  logic        last_e;
  int model_last = REQS - 1;

  always @(posedge axis_clk) cyc++;

  // Mid-cycle monitor: command handshakes and response pulses.
  always @(negedge axis_clk) begin
    if (m_cmd_valid && m_cmd_ready) hs_n++;
    if (resp_valid !== '0) begin
      resp_n++;
      last_cyc = cyc;
      last_v   = resp_valid;
      last_d   = resp_data;
      last_e   = resp_err;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Round-robin reference: first valid requester above last, wrapping.
  function automatic int rr(input logic [1:0] v, input int last);
    int c;
    for (int k = 1; k <= REQS; k++) begin
      c = (last + k) % REQS;
      if (((v >> c) & 2'b01) != 2'b00) return c;
    end
    return -1;
  endfunction

  function automatic logic [31:0] mk_word(input bit regen);
    logic [31:0] w;
    w = $urandom;
    w[GP_PORT_DRP_REGEN] = regen;
    return w;
  endfunction

  task automatic wait_resp(input int base, output bit got);
    int guard;
    guard = 0;
    while (resp_n == base && guard < 100) begin
      @(negedge axis_clk);
      guard++;
    end
    got = (resp_n != base);
  endtask

  // One complete transaction: present, check grant, play the bridge, check
  // the response and its timing.
  task automatic do_txn(input logic [1:0] vmask, input logic [31:0] w0, input logic [31:0] w1,
                        input logic [31:0] stat, input int lat, input bit simul);
    int win, acc, base, hs_base, exp_lat;
    logic [31:0] word;
    bit got;
    win  = rr(vmask, model_last);
    word = (win == 0) ? w0 : w1;
    base = resp_n;
    hs_base = hs_n;
    @(posedge axis_clk); #1;
    req_data    = {w1, w0};
    req_valid   = vmask;
    m_cmd_ready = 1'b1;
    m_drdy      = 1'b0;
    m_stat_data = word[GP_PORT_DRP_REGEN] ? $urandom : stat;
    @(negedge axis_clk);
    check("req_ready", 32'(req_ready), 32'd1 << win);
    acc = cyc;
    @(posedge axis_clk); #1;
    req_valid = '0;
    req_data  = {$urandom, $urandom};
    @(negedge axis_clk);
    check("cmd_valid_issue", 32'(m_cmd_valid), 32'd1);
    check("cmd_data_issue", m_cmd_data, word);
    if (word[GP_PORT_DRP_REGEN]) begin
      @(posedge axis_clk); #1;
      m_cmd_ready = 1'b0;
      m_stat_data = $urandom;
      repeat (lat - 1) @(posedge axis_clk);
      #1;
      m_drdy      = 1'b1;
      m_stat_data = stat;
      m_cmd_ready = simul;
      @(posedge axis_clk); #1;
      m_drdy      = 1'b0;
      m_stat_data = $urandom;
      m_cmd_ready = 1'b1;
      exp_lat = simul ? lat + 3 : lat + 4;
    end else begin
      @(posedge axis_clk); #1;
      m_stat_data = $urandom;
      exp_lat = 3;
    end
    wait_resp(base, got);
    check("resp_arrived", 32'(got), 32'd1);
    if (got) begin
      check("resp_latency", 32'(last_cyc - acc), 32'(exp_lat));
      check("resp_valid", 32'(last_v), 32'd1 << win);
      check("resp_data", last_d, stat);
      check("resp_err", 32'(last_e), 32'd0);
    end
    repeat (2) @(negedge axis_clk);
    check("single_pulse", resp_n, base + 1);
    check("one_handshake", hs_n, hs_base + 1);
    check("cmd_data_hold", m_cmd_data, word);
    model_last = win;
  endtask

  initial begin
    logic [31:0] s;
    int base, acc, hs_base;
    bit got;

    // Reset state, with requests already pending.
    req_valid   = 2'b11;
    req_data    = {$urandom, $urandom};
    m_cmd_ready = 1'b1;
    m_drdy      = 1'b0;
    m_stat_data = $urandom;
    #2;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_cmd_valid", 32'(m_cmd_valid), 32'd0);
    check("rst_cmd_data", m_cmd_data, 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    req_valid = '0;
    repeat (2) @(posedge axis_clk);
    @(negedge axis_clk);
    reset_n = 1'b1;

    // Single-requester DRP read, drdy 5 cycles after the handshake.
    s = {16'($urandom), 16'h1234};
    do_txn(2'b01, mk_word(1'b1), mk_word(1'b0), s, 5, 1'b0);

    // GPIO-only command from requester 1.
    do_txn(2'b10, mk_word(1'b1), mk_word(1'b0), $urandom, 1, 1'b0);

    // Fairness: both requesting for six transactions.
    for (int t = 0; t < 6; t++) begin
      check("fair_order", 32'(rr(2'b11, model_last)), 32'(t % 2));
      do_txn(2'b11, mk_word(1'($urandom)), mk_word(1'($urandom)), $urandom,
             int'($urandom_range(1, 6)), 1'($urandom));
    end

    // drdy and ready rising together.
    do_txn(2'b01, mk_word(1'b1), mk_word(1'b1), $urandom, 3, 1'b1);

    // Random mix.
    for (int t = 0; t < 6; t++) begin
      do_txn(2'($urandom_range(1, 3)), mk_word(1'($urandom)), mk_word(1'($urandom)),
             $urandom, int'($urandom_range(1, 8)), 1'($urandom));
    end

`ifdef UL_DRP_ARB_TIMEOUT_EN
    // Timeout: drdy never arrives, bridge stays not-ready.
    base = resp_n;
    @(posedge axis_clk); #1;
    req_data  = {mk_word(1'b1), mk_word(1'b1)};
    req_valid = 2'b01;
    m_cmd_ready = 1'b1;
    @(negedge axis_clk);
    check("to_req_ready", 32'(req_ready), 32'd1);
    acc = cyc;
    @(posedge axis_clk); #1;
    req_valid = '0;
    @(posedge axis_clk); #1;
    m_cmd_ready = 1'b0;
    wait_resp(base, got);
    check("to_arrived", 32'(got), 32'd1);
    // ISSUE + (TO_CYCLES+1) WAIT cycles + RESP + pulse
    check("to_latency", 32'(last_cyc - acc), 32'(TO_CYCLES + 4));
    check("to_err", 32'(last_e), 32'd1);
    check("to_data", last_d, 32'd0);
    check("to_valid", 32'(last_v), 32'd1);
    model_last = 0;

    // Next command stalls in ISSUE until ready returns.
    base = resp_n;
    hs_base = hs_n;
    s = $urandom;
    @(posedge axis_clk); #1;
    req_data  = {mk_word(1'b0), mk_word(1'b0)};
    req_valid = 2'b01;
    @(negedge axis_clk);
    check("stall_req_ready", 32'(req_ready), 32'd1);
    @(posedge axis_clk); #1;
    req_valid = '0;
    repeat (5) @(negedge axis_clk);
    check("stall_cmd_valid", 32'(m_cmd_valid), 32'd1);
    check("stall_no_hs", hs_n, hs_base);
    @(posedge axis_clk); #1;
    m_cmd_ready = 1'b1;
    m_stat_data = s;
    wait_resp(base, got);
    check("stall_arrived", 32'(got), 32'd1);
    check("stall_data", last_d, s);
    check("stall_err", 32'(last_e), 32'd0);
    model_last = 0;
`endif

    // Reset in the middle of WAIT.
    base = resp_n;
    @(posedge axis_clk); #1;
    req_data    = {mk_word(1'b1), mk_word(1'b1)};
    req_valid   = 2'b11;
    m_cmd_ready = 1'b1;
    @(posedge axis_clk); #1;
    req_valid = '0;
    @(posedge axis_clk); #1;
    m_cmd_ready = 1'b0;
    repeat (3) @(posedge axis_clk);
    #2;
    req_valid = 2'b11;
    reset_n   = 1'b0;
    #1;
    check("mid_req_ready", 32'(req_ready), 32'd0);
    check("mid_cmd_valid", 32'(m_cmd_valid), 32'd0);
    check("mid_cmd_data", m_cmd_data, 32'd0);
    check("mid_resp_valid", 32'(resp_valid), 32'd0);
    check("mid_resp_data", resp_data, 32'd0);
    check("mid_resp_err", 32'(resp_err), 32'd0);
    @(posedge axis_clk); #1;
    req_valid   = '0;
    m_drdy      = 1'b1;
    m_cmd_ready = 1'b1;
    @(negedge axis_clk);
    reset_n    = 1'b1;
    model_last = REQS - 1;
    @(posedge axis_clk); #1;
    m_drdy = 1'b0;
    repeat (10) @(negedge axis_clk);
    check("mid_no_resp", resp_n, base);
    check("mid_idle", 32'(m_cmd_valid), 32'd0);

    // Requester 0 wins first again after reset.
    do_txn(2'b11, mk_word(1'b0), mk_word(1'b1), $urandom, 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
